// File: rtl/dual_port_mem_responder_pkg.sv
// Shared types and constants for the dual-port memory responder: FSM state
// encoding, word width, default RAM address width and per-port operation record.
package dual_port_mem_responder_pkg;

    localparam int WORD_W         = 16;
    localparam int DEFAULT_ADDR_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OP1,
        ST_OP2,
        ST_FIN,
        ST_DONE
    } state_t;

    // Address is kept outside this record because its width is a module parameter.
    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [WORD_W-1:0] wdata;
    } port_op_t;

    // A port that strobes both read and write performs only the write.
    function automatic logic op_reads(input port_op_t op);
        return op.rd && !op.wr;
    endfunction

    function automatic logic op_conflict(input logic rd, input logic wr);
        return rd && wr;
    endfunction

endpackage

// File: rtl/dual_port_mem_responder_spram16.sv
// Single-port synchronous RAM, 16-bit words: write commits at the clock edge,
// read data is registered and appears one cycle after the read is launched.
module spram16
    import dual_port_mem_responder_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] q
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    // NOTE: the array and its output register carry no reset; a reset loop over
    // every word would stop this mapping onto a RAM macro, and stored contents
    // are meant to survive a responder reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/dual_port_mem_responder.sv
// Memory responder: latches a two-port request bundle and serialises port 1 then
// port 2 onto one single-port RAM, returning registered read data and a Done pulse.
module dual_port_mem_responder
    import dual_port_mem_responder_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              CLK,
    input  logic              RstN,
    input  logic              Req,
    input  logic              Read1,
    input  logic              Write1,
    input  logic [15:0]       Addr1,
    input  logic [15:0]       WrData1,
    input  logic              Read2,
    input  logic              Write2,
    input  logic [15:0]       Addr2,
    input  logic [15:0]       WrData2,
    output logic [15:0]       RdData1,
    output logic [15:0]       RdData2,
    output logic              Busy,
    output logic              Done,
    output logic              ErrFlag
);

    state_t            state;
    port_op_t          op1;
    port_op_t          op2;
    logic [ADDR_W-1:0] addr1_q;
    logic [ADDR_W-1:0] addr2_q;

    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_q;

    // Address bits above the RAM depth are ignored, so addresses wrap.
    generate
        if (ADDR_W < 16) begin : g_addr_wrap
            logic unused_addr_hi;
            assign unused_addr_hi = ^{Addr1[15:ADDR_W], Addr2[15:ADDR_W]};
        end
    endgenerate

    // NOTE: every signal driven here gets a default before the case, so states
    // that do not touch the RAM cannot leave a path that infers a latch.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state)
            ST_OP1: begin
                ram_we    = op1.wr;
                ram_re    = op_reads(op1);
                ram_addr  = addr1_q;
                ram_wdata = op1.wdata;
            end
            ST_OP2: begin
                ram_we    = op2.wr;
                ram_re    = op_reads(op2);
                ram_addr  = addr2_q;
                ram_wdata = op2.wdata;
            end
            default: ;
        endcase
    end

    spram16 #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (CLK),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    // NOTE: all state and output registers use non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (!RstN) begin
            state   <= ST_IDLE;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            ErrFlag <= 1'b0;
            RdData1 <= '0;
            RdData2 <= '0;
            op1     <= '0;
            op2     <= '0;
            addr1_q <= '0;
            addr2_q <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    Done <= 1'b0;
                    if (Req) begin
                        op1     <= '{rd: Read1, wr: Write1, wdata: WrData1};
                        op2     <= '{rd: Read2, wr: Write2, wdata: WrData2};
                        addr1_q <= Addr1[ADDR_W-1:0];
                        addr2_q <= Addr2[ADDR_W-1:0];
                        Busy    <= 1'b1;
                        state   <= ST_OP1;
                        if (op_conflict(Read1, Write1) || op_conflict(Read2, Write2)) begin
                            ErrFlag <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_OP1: begin
                    state <= ST_OP2;
                end
                ST_OP2: begin
                    // RAM q now holds the word launched by port 1 in OP1.
                    if (op_reads(op1)) begin
                        RdData1 <= ram_q;
                    end
                    state <= ST_FIN;
                end
                ST_FIN: begin
                    if (op_reads(op2)) begin
                        RdData2 <= ram_q;
                    end
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                    state <= ST_DONE;
                end
                default: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase

            // Busy is high exactly in OP1/OP2/FIN, so this flags every dropped Req.
            if (Req && Busy) begin
                ErrFlag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Self-checking bench for dual_port_mem_responder: directed vector table,
// hand-written corner sequences and randomized requests against a memory model.
module tb_dual_port_mem_responder;

    localparam int ADDR_W = 10;

    logic        CLK;
    logic        RstN;
    logic        Req;
    logic        Read1, Write1, Read2, Write2;
    logic [15:0] Addr1, WrData1, Addr2, WrData2;
    logic [15:0] RdData1, RdData2;
    logic        Busy, Done, ErrFlag;

    dual_port_mem_responder #(.ADDR_W(ADDR_W)) dut (
        .CLK     (CLK),
        .RstN    (RstN),
        .Req     (Req),
        .Read1   (Read1),
        .Write1  (Write1),
        .Addr1   (Addr1),
        .WrData1 (WrData1),
        .Read2   (Read2),
        .Write2  (Write2),
        .Addr2   (Addr2),
        .WrData2 (WrData2),
        .RdData1 (RdData1),
        .RdData2 (RdData2),
        .Busy    (Busy),
        .Done    (Done),
        .ErrFlag (ErrFlag)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        r1, w1;
        logic [15:0] a1, d1;
        logic        r2, w2;
        logic [15:0] a2, d2;
    } req_t;

    typedef struct {
        req_t        req;
        logic [15:0] e_rd1;
        logic [15:0] e_rd2;
        logic        e_err;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the memory as an array plus the visible result registers.
    logic [15:0] mem_m [1024];
    logic [15:0] m_rd1, m_rd2;
    logic        m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic req_t mk(input logic r1, input logic w1, input logic [15:0] a1,
                                input logic [15:0] d1, input logic r2, input logic w2,
                                input logic [15:0] a2, input logic [15:0] d2);
        req_t r;
        r.r1 = r1; r.w1 = w1; r.a1 = a1; r.d1 = d1;
        r.r2 = r2; r.w2 = w2; r.a2 = a2; r.d2 = d2;
        return r;
    endfunction

    // Port 1 fully completes before port 2; a write wins over a read on one port.
    task automatic model_apply(input req_t r);
        logic [9:0] i1, i2;
        i1 = r.a1[9:0];
        i2 = r.a2[9:0];
        if (r.w1) mem_m[i1] = r.d1;
        else if (r.r1) m_rd1 = mem_m[i1];
        if (r.w2) mem_m[i2] = r.d2;
        else if (r.r2) m_rd2 = mem_m[i2];
        if ((r.r1 && r.w1) || (r.r2 && r.w2)) m_err = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge of the Done cycle (k+4).
    // intrude = 1..3 pulses an extra Req during that busy cycle.
    task automatic do_req(input req_t r, input int intrude);
        Read1 = r.r1; Write1 = r.w1; Addr1 = r.a1; WrData1 = r.d1;
        Read2 = r.r2; Write2 = r.w2; Addr2 = r.a2; WrData2 = r.d2;
        Req = 1'b1;
        @(negedge CLK);
        Req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("busy_c%0d", c), Busy, 1'b1);
            check($sformatf("nodone_c%0d", c), Done, 1'b0);
            if (c == intrude) begin
                Req = 1'b1; Read1 = 1'b0; Write1 = 1'b1;
                Addr1 = 16'h0061; WrData1 = 16'hDEAD;
            end
            @(negedge CLK);
            Req = 1'b0;
        end
        check("done_k4", Done, 1'b1);
        check("busy_k4", Busy, 1'b0);
    endtask

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t r;
        int   k;

        vecs[0] = '{mk(0, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0000, 16'h0000), 16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0010, 16'h0000), 16'h0000, 16'hBEEF, 1'b0};
        vecs[2] = '{mk(0, 1, 16'h0020, 16'h1111, 0, 1, 16'h0020, 16'h2222), 16'h0000, 16'hBEEF, 1'b0};
        vecs[3] = '{mk(1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 16'h0000), 16'h2222, 16'hBEEF, 1'b0};
        vecs[4] = '{mk(0, 1, 16'h0030, 16'hA5A5, 1, 0, 16'h0030, 16'h0000), 16'h2222, 16'hA5A5, 1'b0};
        vecs[5] = '{mk(0, 1, 16'h0040, 16'h0001, 0, 0, 16'h0000, 16'h0000), 16'h2222, 16'hA5A5, 1'b0};
        vecs[6] = '{mk(1, 0, 16'h0040, 16'h0000, 0, 1, 16'h0040, 16'h0002), 16'h0001, 16'hA5A5, 1'b0};
        vecs[7] = '{mk(1, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 16'h0000), 16'h0002, 16'hA5A5, 1'b0};
        vecs[8] = '{mk(0, 1, 16'h0405, 16'h7E57, 1, 0, 16'h0005, 16'h0000), 16'h0002, 16'h7E57, 1'b0};

        RstN = 1'b0; Req = 1'b0;
        Read1 = 1'b0; Write1 = 1'b0; Addr1 = '0; WrData1 = '0;
        Read2 = 1'b0; Write2 = 1'b0; Addr2 = '0; WrData2 = '0;
        m_rd1 = '0; m_rd2 = '0; m_err = 1'b0;

        repeat (3) @(negedge CLK);
        check("rst_busy", Busy, 1'b0);
        check("rst_done", Done, 1'b0);
        check("rst_err", ErrFlag, 1'b0);
        check("rst_rd1", RdData1, 16'h0000);
        check("rst_rd2", RdData2, 16'h0000);
        RstN = 1'b1;
        @(negedge CLK);

        // Preload words 0..127 with known contents, two per request.
        for (int i = 0; i < 64; i++) begin
            r = mk(0, 1, 16'(2 * i), 16'h5A00 | 16'(2 * i),
                   0, 1, 16'(2 * i + 1), 16'h5A00 | 16'(2 * i + 1));
            do_req(r, 0);
            model_apply(r);
        end

        for (int i = 0; i < 9; i++) begin
            do_req(vecs[i].req, 0);
            model_apply(vecs[i].req);
            check($sformatf("vec%0d_rd1", i), RdData1, vecs[i].e_rd1);
            check($sformatf("vec%0d_rd2", i), RdData2, vecs[i].e_rd2);
            check($sformatf("vec%0d_err", i), ErrFlag, vecs[i].e_err);
        end

        // Req during OP2 is dropped and flagged; original timing is kept.
        r = mk(1, 0, 16'h0060, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        do_req(r, 2);
        model_apply(r);
        m_err = 1'b1;
        check("intr_rd1", RdData1, 16'h5A60);
        check("intr_err", ErrFlag, 1'b1);
        r = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0061, 16'h0000);
        do_req(r, 0);
        model_apply(r);
        check("intr_nowrite", RdData2, 16'h5A61);

        // Reset during OP1: port-1 write already committed, port-2 write lost.
        Read1 = 1'b0; Write1 = 1'b1; Addr1 = 16'h0050; WrData1 = 16'h1234;
        Read2 = 1'b0; Write2 = 1'b1; Addr2 = 16'h0051; WrData2 = 16'h5678;
        Req = 1'b1;
        @(negedge CLK);
        Req = 1'b0;
        RstN = 1'b0;
        @(negedge CLK);
        RstN = 1'b1;
        check("mid_rst_busy", Busy, 1'b0);
        check("mid_rst_done", Done, 1'b0);
        check("mid_rst_err", ErrFlag, 1'b0);
        check("mid_rst_rd1", RdData1, 16'h0000);
        check("mid_rst_rd2", RdData2, 16'h0000);
        mem_m[10'h050] = 16'h1234;
        m_rd1 = '0; m_rd2 = '0; m_err = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            check($sformatf("mid_rst_nodone%0d", c), Done, 1'b0);
        end
        r = mk(1, 0, 16'h0050, 16'h0000, 1, 0, 16'h0051, 16'h0000);
        do_req(r, 0);
        model_apply(r);
        check("post_rst_rd1", RdData1, 16'h1234);
        check("post_rst_rd2", RdData2, 16'h5A51);
        check("post_rst_err", ErrFlag, 1'b0);

        // Read and write on one port: write executes, read dropped, error flagged.
        r = mk(1, 1, 16'h0070, 16'hC0DE, 1, 0, 16'h0070, 16'h0000);
        do_req(r, 0);
        model_apply(r);
        check("rdwr_rd1", RdData1, 16'h1234);
        check("rdwr_rd2", RdData2, 16'hC0DE);
        check("rdwr_err", ErrFlag, 1'b1);

        // Randomized requests against the model, with optional idle gaps.
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 2);
            if (k > 0) begin
                repeat (k) @(negedge CLK);
                check($sformatf("rnd%0d_idle_done", n), Done, 1'b0);
                check($sformatf("rnd%0d_idle_busy", n), Busy, 1'b0);
            end
            k = $urandom_range(0, 9);
            r.r1 = (k <= 3) || (k == 9);
            r.w1 = (k >= 4 && k <= 7) || (k == 9);
            k = $urandom_range(0, 9);
            r.r2 = (k <= 3) || (k == 9);
            r.w2 = (k >= 4 && k <= 7) || (k == 9);
            r.a1 = 16'($urandom_range(0, 127)) | 16'($urandom_range(0, 63) << 10);
            r.a2 = 16'($urandom_range(0, 127)) | 16'($urandom_range(0, 63) << 10);
            r.d1 = 16'($urandom);
            r.d2 = 16'($urandom);
            do_req(r, 0);
            model_apply(r);
            check($sformatf("rnd%0d_rd1", n), RdData1, m_rd1);
            check($sformatf("rnd%0d_rd2", n), RdData2, m_rd2);
            check($sformatf("rnd%0d_err", n), ErrFlag, m_err);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_port_mem_responder.md
# dual_port_mem_responder

Memory-side responder for the control unit's two memory request channels (port 1 / port 2: read/write strobes, address, write data). Accepts one request bundle per Req pulse and services the two channels in a fixed order against one internal single-port synchronous RAM, so a single control state may issue a stack push and a load together. Returns registered read data with a one-cycle Done pulse at fixed latency, and sits between the datapath's memory address/data muxes and the stack/program storage.

## Interface
- ADDR_W, 10: RAM address width; depth = 2^ADDR_W words of 16 bits
- CLK  in  1  rising-edge clock, single domain
- RstN  in  1  synchronous, active-low reset
- Req  in  1  single-cycle pulse; samples all port-1/port-2 inputs
- Read1, Write1  in  1 each  port-1 operation strobes
- Addr1  in  16  port-1 word address (low ADDR_W bits used)
- WrData1  in  16  port-1 write data
- Read2, Write2, Addr2, WrData2  in  1/1/16/16  port-2 equivalents
- RdData1  out  16  port-1 read result, held until next port-1 read completes
- RdData2  out  16  port-2 read result, same hold rule
- Busy  out  1  request in flight
- Done  out  1  one-cycle completion pulse
- ErrFlag  out  1  sticky protocol error, cleared only by reset

## Operation
- States: IDLE, OP1, OP2, FIN, DONE. IDLE/DONE accept Req; OP1/OP2/FIN do not.
- Req in IDLE or DONE: latch Read/Write/Addr/WrData of both ports, go to OP1. Without Req: DONE→IDLE.
- OP1: present port-1 op to RAM (write commits at end of cycle; read launches). → OP2.
- OP2: present port-2 op; if port-1 was a read, RdData1 <= RAM q at end of cycle. → FIN.
- FIN: if port-2 was a read, RdData2 <= RAM q at end of cycle. → DONE.
- Port with no strobe: its slot is an idle RAM cycle; latency unchanged; its RdData unchanged.
- Read and Write both set on one port: write executes, read dropped, ErrFlag set.
- Req while Busy: ignored, in-flight op unaffected, ErrFlag set.
- Ordering: port 1 strictly before port 2. Same-address write1+write2 → port-2 data persists; write1+read2 → RdData2 = WrData1; read1+write2 → RdData1 = old contents.
- Addresses ≥ 2^ADDR_W wrap (upper bits ignored).

## Timing
- Req at edge k → Busy high for cycles k+1..k+3 (OP1, OP2, FIN), Done high in cycle k+4 only; RdData1/RdData2 valid from cycle k+4.
- Back-to-back: Req in the Done cycle restarts; throughput one request per 4 cycles.
- Busy and Done are registered and never high together.
- Reset (RstN low at edge): state IDLE; Busy, Done, ErrFlag = 0; RdData1, RdData2 = 16'h0000. RAM array not cleared. Reset mid-operation aborts it; a write already committed stays, an uncommitted one is lost; no Done.

## Structure
- Shared package: state encoding (IDLE, OP1, OP2, FIN, DONE), word width 16, default ADDR_W.
- Sub-module spram16: single-port RAM, synchronous write, registered read (1-cycle), no reset on array. Responder holds the FSM, request latch, RAM mux and output registers.

## Test plan
- Write1 Addr1=0x010 WrData1=0xBEEF, port 2 idle; then Read2 Addr2=0x010 → second request: Done at k+4, RdData2=0xBEEF, RdData1 unchanged.
- Write1 0x020=0x1111 and Write2 0x020=0x2222 in one Req; then Read1 0x020 → RdData1=0x2222.
- Write1 0x030=0xA5A5 with Read2 0x030 in one Req → RdData2=0xA5A5; preload 0x040=0x0001, Read1 0x040 with Write2 0x040=0x0002 → RdData1=0x0001.
- Req during OP2 → ignored, ErrFlag=1, original Done still at k+4; Read1+Write1 on one port → write done, ErrFlag=1.
- Write to Addr1=0x0405 (ADDR_W=10), Read Addr2=0x0005 → same word returned.
- RstN low in OP1 of a write → Busy=0, Done never pulses, RdData=0x0000, ErrFlag=0; Req in Done cycle → Busy next cycle, Done exactly 4 cycles later.
